// File: rtl/frame_power_meter_pkg.sv
// Shared types and sizing helpers for the frame power meter and related level blocks.
package frame_power_meter_pkg;

    localparam int unsigned SAMPLE_W_DEF = 24;

    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

    typedef enum logic {
        SlotEmpty,
        SlotFull
    } slot_state_e;

    // A frame of 2^len_log2 squares of sample_w-bit samples never exceeds this width.
    function automatic int unsigned acc_width(input int unsigned sample_w,
                                              input int unsigned len_log2);
        return 2 * sample_w + len_log2;
    endfunction

endpackage

// File: rtl/frame_power_meter_if.sv
// Sample stream in, frame result out through a valid/ready register.
interface frame_power_meter_if
    import frame_power_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned OUT_W    = 48
);
    logic signed [SAMPLE_W-1:0] sample_i;
    logic                       sample_valid_i;
    logic [OUT_W-1:0]           power_o;
    logic [SAMPLE_W-1:0]        peak_o;
    logic                       power_valid_o;
    logic                       power_ready_i;
    logic                       overrun_o;
    logic [15:0]                frame_count_o;

    modport slave (
        input  sample_i, sample_valid_i, power_ready_i,
        output power_o, peak_o, power_valid_o, overrun_o, frame_count_o
    );

    modport master (
        output sample_i, sample_valid_i, power_ready_i,
        input  power_o, peak_o, power_valid_o, overrun_o, frame_count_o
    );
endinterface

// File: rtl/sq_mag_stage.sv
// Registered magnitude and square of a signed sample; valid/last ride along unchanged.
module sq_mag_stage #(
    parameter int unsigned SAMPLE_W = 24
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    output logic [SAMPLE_W-1:0]        mag_o,
    output logic [2*SAMPLE_W-1:0]      sq_o,
    output logic                       valid_o,
    output logic                       last_o
);
    logic [SAMPLE_W-1:0]   mag_d, mag_q;
    logic [2*SAMPLE_W-1:0] mag_ext;
    logic [2*SAMPLE_W-1:0] sq_d, sq_q;
    logic                  valid_q, last_q;

    always_comb begin
        // Negating the most negative code wraps to 100..0, which read unsigned is 2^(SAMPLE_W-1).
        mag_d   = sample_i[SAMPLE_W-1] ? SAMPLE_W'(-sample_i) : SAMPLE_W'(sample_i);
        mag_ext = {{SAMPLE_W{1'b0}}, mag_d};
        sq_d    = mag_ext * mag_ext;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mag_q   <= '0;
            sq_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            mag_q   <= mag_d;
            sq_q    <= sq_d;
            valid_q <= valid_i;
            last_q  <= valid_i && last_i;
        end
    end

    assign mag_o   = mag_q;
    assign sq_o    = sq_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/frame_power_meter.sv
// Mean power and peak magnitude over fixed frames of 2^FRAME_LEN_LOG2 samples,
// presented through a single-entry valid/ready result register.
module frame_power_meter
    import frame_power_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W       = SAMPLE_W_DEF,
    parameter int unsigned FRAME_LEN_LOG2 = 10,
    parameter int unsigned OUT_W          = 48
) (
    input logic                clk_i,
    input logic                rst_i,
    frame_power_meter_if.slave meter_io
);
    localparam int unsigned ACC_W = acc_width(SAMPLE_W, FRAME_LEN_LOG2);
    localparam int unsigned SQ_W  = 2 * SAMPLE_W;

    // S1: sample capture and frame position
    logic [FRAME_LEN_LOG2-1:0]  cnt_q;
    logic signed [SAMPLE_W-1:0] s1_sample_q;
    logic                       s1_valid_q;
    logic                       s1_last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            s1_sample_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
        end else begin
            s1_valid_q <= meter_io.sample_valid_i;
            s1_last_q  <= meter_io.sample_valid_i && (cnt_q == '1);
            if (meter_io.sample_valid_i) begin
                cnt_q       <= cnt_q + FRAME_LEN_LOG2'(1);
                s1_sample_q <= meter_io.sample_i;
            end
        end
    end

    // S2: magnitude and square
    logic [SAMPLE_W-1:0] s2_mag;
    logic [SQ_W-1:0]     s2_sq;
    logic                s2_valid;
    logic                s2_last;

    sq_mag_stage #(
        .SAMPLE_W (SAMPLE_W)
    ) u_sq_mag (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sample_i (s1_sample_q),
        .valid_i  (s1_valid_q),
        .last_i   (s1_last_q),
        .mag_o    (s2_mag),
        .sq_o     (s2_sq),
        .valid_o  (s2_valid),
        .last_o   (s2_last)
    );

    // S3: accumulate and track peak; the last sample folds straight into the result
    logic [ACC_W-1:0]    acc_q, acc_d, frame_sum, frame_mean;
    logic [SAMPLE_W-1:0] run_peak_q, run_peak_d, frame_peak;
    logic                frame_done;

    always_comb begin
        frame_sum  = acc_q + ACC_W'(s2_sq);
        frame_mean = frame_sum >> FRAME_LEN_LOG2;
        frame_peak = (s2_mag > run_peak_q) ? s2_mag : run_peak_q;
        frame_done = s2_valid && s2_last;
        acc_d      = acc_q;
        run_peak_d = run_peak_q;
        if (s2_valid) begin
            acc_d      = s2_last ? '0 : frame_sum;
            run_peak_d = s2_last ? '0 : frame_peak;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            run_peak_q <= '0;
        end else begin
            acc_q      <= acc_d;
            run_peak_q <= run_peak_d;
        end
    end

    // Result slot
    slot_state_e      slot_q, slot_d;
    logic             load_result;
    logic             drop_result;
    logic [OUT_W-1:0] power_q;
    logic [SAMPLE_W-1:0] peak_q;
    logic             overrun_q;
    logic [15:0]      frame_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= SlotEmpty;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SlotEmpty: if (frame_done) slot_d = SlotFull;
            SlotFull:  if (!frame_done && meter_io.power_ready_i) slot_d = SlotEmpty;
            default:   slot_d = SlotEmpty;
        endcase
    end

    always_comb begin
        // A full slot being consumed this cycle can take the new result in its place.
        load_result = frame_done && ((slot_q == SlotEmpty) || meter_io.power_ready_i);
        drop_result = frame_done && (slot_q == SlotFull) && !meter_io.power_ready_i;
        meter_io.power_valid_o = (slot_q == SlotFull);
        meter_io.power_o       = power_q;
        meter_io.peak_o        = peak_q;
        meter_io.overrun_o     = overrun_q;
        meter_io.frame_count_o = frame_count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            power_q       <= '0;
            peak_q        <= '0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (load_result) begin
                power_q <= OUT_W'(frame_mean);
                peak_q  <= frame_peak;
            end
            if (drop_result) begin
                overrun_q <= 1'b1;
            end
            if (frame_done) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

endmodule
